// File: rtl/shift_reg_reader.sv
// Serial reader for parallel-in/serial-out shift-register chains (e.g. '165 DIP banks).
// Latches the chain, shifts a word in MSB first, and keeps a debounced copy of it.
module shift_reg_reader #(
  parameter int WIDTH        = 16,
  parameter int LOAD_CYCLES  = 2,
  parameter int STABLE_SCANS = 3,
  parameter int AUTO         = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_data,
  output logic             o_latch,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_stable,
  output logic             o_changed
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(LOAD_CYCLES + 1);
  localparam int MW = $clog2(STABLE_SCANS + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [LW-1:0] LOAD_ONE  = LW'(1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_SCANS);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic [LW-1:0]    load_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             hist_valid;
  logic [MW-1:0]    match_cnt;

  logic             load_done;
  logic             shift_done;
  logic [WIDTH-1:0] word_next;
  logic [MW-1:0]    match_next;
  logic             take_stable;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (AUTO != 0 || i_start) state_next = LOAD;
      LOAD:  if (load_done) state_next = SHIFT;
      SHIFT: if (shift_done) state_next = DONE;
      DONE:  state_next = (AUTO != 0) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_latch = (state != LOAD);
    o_busy  = (state != IDLE);
  end

  // The final sample edge is also the edge entering DONE, so the word and the
  // debounce decision are built from the shift register plus the live bit.
  always_comb begin
    load_done  = (state == LOAD) && (load_cnt == LOAD_LAST);
    shift_done = (state == SHIFT) && (bit_cnt == BIT_LAST);
    word_next  = {shreg[WIDTH-2:0], i_data};
    if (hist_valid && word_next == o_data)
      match_next = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MATCH_ONE;
    else
      match_next = MATCH_ONE;
    take_stable = (match_next == MATCH_MAX) && (word_next != o_stable);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      hist_valid <= 1'b0;
      match_cnt  <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_stable   <= '0;
      o_changed  <= 1'b0;
    end else begin
      load_cnt  <= (state == LOAD && !load_done) ? load_cnt + LOAD_ONE : '0;
      bit_cnt   <= (state == SHIFT && !shift_done) ? bit_cnt + BIT_ONE : '0;
      o_valid   <= 1'b0;
      o_changed <= 1'b0;
      if (state == SHIFT) shreg <= word_next;
      if (shift_done) begin
        o_data     <= word_next;
        o_valid    <= 1'b1;
        hist_valid <= 1'b1;
        match_cnt  <= match_next;
        if (take_stable) begin
          o_stable  <= word_next;
          o_changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_reader.sv
// Self-checking bench for shift_reg_reader with a behavioural '165 chain model
// and a scoreboard of expected (word, changed, stable) per scan.
module tb_shift_reg_reader;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         i_start = 1'b0;
  logic         i_data;
  logic         o_latch, o_busy, o_valid, o_changed;
  logic [W-1:0] o_data, o_stable;

  logic         start_a = 1'b0;
  logic         data_a;
  logic         latch_a, busy_a, valid_a, changed_a;
  logic [W-1:0] odata_a, stable_a;

  logic [W-1:0] par = 16'hA5C3;
  logic [W-1:0] sr = '0;
  logic [W-1:0] sr_a = '0;

  shift_reg_reader #(.WIDTH(W), .LOAD_CYCLES(2), .STABLE_SCANS(3), .AUTO(0)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_data(i_data),
    .o_latch(o_latch), .o_busy(o_busy), .o_data(o_data), .o_valid(o_valid),
    .o_stable(o_stable), .o_changed(o_changed)
  );

  shift_reg_reader #(.WIDTH(W), .LOAD_CYCLES(2), .STABLE_SCANS(3), .AUTO(1)) dut_auto (
    .clk(clk), .reset(reset), .i_start(start_a), .i_data(data_a),
    .o_latch(latch_a), .o_busy(busy_a), .o_data(odata_a), .o_valid(valid_a),
    .o_stable(stable_a), .o_changed(changed_a)
  );

  // '165 behaviour: parallel load while latch is low, shift MSB-first otherwise.
  always @(posedge clk) begin
    if (!o_latch) sr <= par;
    else          sr <= {sr[W-2:0], 1'b0};
    if (!latch_a) sr_a <= 16'hA5C3;
    else          sr_a <= {sr_a[W-2:0], 1'b0};
  end
  assign i_data = sr[W-1];
  assign data_a = sr_a[W-1];

  typedef struct packed {
    logic [W-1:0] data;
    logic         changed;
    logic [W-1:0] stable;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   changed_cnt = 0;

  // Scoreboard monitor: every o_valid pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (o_changed) changed_cnt++;
      if (o_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_valid: o_data=%h, no scan was expected", o_data);
        end else begin
          e = sb.pop_front();
          checks++;
          if (o_data !== e.data) begin
            errors++;
            $display("[TB] FAIL sb_data: got %h, expected %h", o_data, e.data);
          end
          checks++;
          if (o_changed !== e.changed) begin
            errors++;
            $display("[TB] FAIL sb_changed: got %b, expected %b", o_changed, e.changed);
          end
          checks++;
          if (o_stable !== e.stable) begin
            errors++;
            $display("[TB] FAIL sb_stable: got %h, expected %h", o_stable, e.stable);
          end
        end
      end else if (o_changed !== 1'b0) begin
        checks++; errors++;
        $display("[TB] FAIL changed_without_valid: got %b, expected 0", o_changed);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    changed_cnt = 0;
  endtask

  task automatic push(input logic [W-1:0] d, input logic c, input logic [W-1:0] s);
    exp_t e;
    e.data = d; e.changed = c; e.stable = s;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!o_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!o_valid) begin
      errors++;
      $display("[TB] FAIL valid_timeout: o_valid=%b after %0d cycles, expected 1", o_valid, n);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({o_latch, o_busy, o_valid, o_changed} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL %s_ctrl: latch/busy/valid/changed=%b, expected 1000", tag,
               {o_latch, o_busy, o_valid, o_changed});
    end
    checks++;
    if (o_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL %s_data: got %h, expected 0000", tag, o_data);
    end
    checks++;
    if (o_stable !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL %s_stable: got %h, expected 0000", tag, o_stable);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    check_reset_values("reset");
  endtask

  task automatic test_single_scan();
    int low = 0, first_low = -1, busy = 0, vk = -1;
    do_reset();
    par = 16'hA5C3;
    push(16'hA5C3, 1'b0, 16'h0000);
    pulse_start();
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (!o_latch) begin
        low++;
        if (first_low < 0) first_low = k;
      end
      if (o_busy) busy++;
      if (o_valid && vk < 0) vk = k;
    end
    checks++;
    if (low !== 2) begin errors++; $display("[TB] FAIL latch_low_len: got %0d, expected 2", low); end
    checks++;
    if (first_low !== 1) begin errors++; $display("[TB] FAIL latch_low_start: got %0d, expected 1", first_low); end
    checks++;
    if (busy !== 19) begin errors++; $display("[TB] FAIL busy_len: got %0d, expected 19", busy); end
    checks++;
    if (vk !== 19) begin errors++; $display("[TB] FAIL valid_latency: got %0d, expected 19", vk); end
    checks++;
    if (o_stable !== 16'h0000) begin errors++; $display("[TB] FAIL single_stable: got %h, expected 0000", o_stable); end
  endtask

  task automatic test_debounce_same();
    do_reset();
    par = 16'hA5C3;
    for (int i = 0; i < 4; i++) begin
      push(16'hA5C3, (i == 2), (i >= 2) ? 16'hA5C3 : 16'h0000);
      pulse_start();
      wait_valid(40);
    end
    checks++;
    if (changed_cnt !== 1) begin errors++; $display("[TB] FAIL same_changed_count: got %0d, expected 1", changed_cnt); end
  endtask

  task automatic test_bounce();
    logic [W-1:0] words [5];
    words = '{16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      par = words[i];
      push(words[i], (i == 4), (i == 4) ? 16'h0001 : 16'h0000);
      pulse_start();
      wait_valid(40);
    end
    checks++;
    if (changed_cnt !== 1) begin errors++; $display("[TB] FAIL bounce_changed_count: got %0d, expected 1", changed_cnt); end
  endtask

  task automatic test_back_to_back();
    int vt [3];
    int nv = 0, extra = 0, vk = -1;
    do_reset();
    par = 16'hA5C3;
    push(16'hA5C3, 1'b0, 16'h0000);
    push(16'hA5C3, 1'b0, 16'h0000);
    push(16'hA5C3, 1'b1, 16'hA5C3);
    @(negedge clk) i_start = 1'b1;
    for (int k = 0; k < 100 && nv < 3; k++) begin
      @(negedge clk);
      if (o_valid) begin
        vt[nv] = k;
        nv++;
        if (nv == 3) i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    checks++;
    if (nv !== 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d, expected 3", nv); end
    else begin
      checks++;
      if (vt[1] - vt[0] !== 20) begin errors++; $display("[TB] FAIL b2b_gap1: got %0d, expected 20", vt[1] - vt[0]); end
      checks++;
      if (vt[2] - vt[1] !== 20) begin errors++; $display("[TB] FAIL b2b_gap2: got %0d, expected 20", vt[2] - vt[1]); end
    end
    repeat (30) begin
      @(negedge clk);
      if (o_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("[TB] FAIL b2b_runon: got %0d valids, expected 0", extra); end
    // One scan with stray start pulses in SHIFT and in DONE.
    push(16'hA5C3, 1'b0, 16'hA5C3);
    pulse_start();
    nv = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (o_valid) begin
        nv++;
        if (vk < 0) vk = k;
      end
      i_start = (k == 10 || k == 19);
    end
    i_start = 1'b0;
    checks++;
    if (vk !== 19) begin errors++; $display("[TB] FAIL midpulse_latency: got %0d, expected 19", vk); end
    checks++;
    if (nv !== 1) begin errors++; $display("[TB] FAIL midpulse_scans: got %0d, expected 1", nv); end
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    par = 16'hA5C3;
    push(16'hA5C3, 1'b0, 16'h0000);
    pulse_start();
    wait_valid(40);
    pulse_start();
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    repeat (30) @(negedge clk);
    push(16'hA5C3, 1'b0, 16'h0000);
    pulse_start();
    wait_valid(40);
  endtask

  task automatic test_auto();
    int n, low;
    n = 0;
    while (!valid_a && n < 40) begin
      @(negedge clk);
      start_a = 1'($urandom_range(0, 1));
      n++;
    end
    checks++;
    if (!valid_a) begin errors++; $display("[TB] FAIL auto_timeout: valid=%b, expected 1", valid_a); end
    for (int p = 0; p < 3; p++) begin
      n = 0; low = 0;
      do begin
        @(negedge clk);
        start_a = 1'($urandom_range(0, 1));
        n++;
        if (!latch_a) low++;
      end while (!valid_a && n < 40);
      checks++;
      if (n !== 19) begin errors++; $display("[TB] FAIL auto_period: got %0d, expected 19", n); end
      checks++;
      if (low !== 2) begin errors++; $display("[TB] FAIL auto_latch_low: got %0d, expected 2", low); end
      checks++;
      if (odata_a !== 16'hA5C3) begin errors++; $display("[TB] FAIL auto_data: got %h, expected a5c3", odata_a); end
    end
    checks++;
    if (stable_a !== 16'hA5C3) begin errors++; $display("[TB] FAIL auto_stable: got %h, expected a5c3", stable_a); end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_scan();
    test_debounce_same();
    test_bounce();
    test_back_to_back();
    test_reset_mid_shift();
    test_auto();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: %0d scans pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
